// File: rtl/midi_note_transmitter.sv
// MIDI note transmitter: turns note-change events into a serial MIDI byte
// stream (8N1, LSB first). It sends Note On / Note Off channel messages and
// can optionally drop the status byte when it repeats (running status).

package midi_pkg;
    typedef struct packed {
        logic       status;       // 1 = Note On, 0 = Note Off
        logic [6:0] note_number;
        logic [6:0] velocity;
    } note_change_t;

    localparam logic NOTE_OFF = 1'b0;
    localparam logic NOTE_ON  = 1'b1;
endpackage

module midi_note_transmitter
    import midi_pkg::*;
#(
    parameter int CLOCK_HZ       = 50_000_000,
    parameter int BAUD           = 31250,
    parameter int CHANNEL        = 0,
    parameter int RUNNING_STATUS = 1
) (
    input  logic         clock_50_000_000,
    input  logic         reset_l,
    input  note_change_t note,
    input  logic         note_valid,
    output logic         note_ready,
    output logic         midi_tx,
    output logic         busy
);

    localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  CHAN_NIB  = 4'(CHANNEL);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // The bit period must be an exact whole number of clocks.
    generate
        if ((CLOCK_HZ % BAUD) != 0 || CLKS_PER_BIT < 1) begin : g_bad_baud
            $error("midi_note_transmitter: CLOCK_HZ must be an integer multiple of BAUD");
        end
        if (CHANNEL < 0 || CHANNEL > 15) begin : g_bad_channel
            $error("midi_note_transmitter: CHANNEL must be 0..15");
        end
    endgenerate

    logic [1:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_idx;     // 0 = status, 1 = data1, 2 = data2
    logic [7:0]        last_status;
    logic              last_valid;

    logic [7:0]        msg_status;
    logic [7:0]        msg_data1;
    logic [7:0]        msg_data2;

    logic [7:0]        next_status;
    logic              skip_status;
    logic              accept;
    logic              baud_done;
    logic [7:0]        cur_byte;

    assign note_ready  = (state == S_IDLE);
    assign busy        = ~note_ready;
    assign accept      = note_ready && note_valid;
    assign baud_done   = (baud_cnt == BAUD_LAST);
    assign next_status = {(note.status == NOTE_ON) ? 4'h9 : 4'h8, CHAN_NIB};
    // A status byte identical to the last completed one may be left out.
    assign skip_status = (RUNNING_STATUS != 0) && last_valid && (next_status == last_status);

    // Select the byte currently being shifted out.
    always_comb begin
        cur_byte = msg_data2;
        case (byte_idx)
            2'd0:    cur_byte = msg_status;
            2'd1:    cur_byte = msg_data1;
            default: cur_byte = msg_data2;
        endcase
    end

    // Capture the message bytes at acceptance; later changes on `note` are ignored.
    always_ff @(posedge clock_50_000_000) begin
        if (accept) begin
            msg_status <= next_status;
            msg_data1  <= {1'b0, note.note_number};
            msg_data2  <= {1'b0, note.velocity};
        end
    end

    // Frame sequencer: start bit, 8 data bits LSB first, stop bit, per byte.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state       <= S_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            midi_tx     <= 1'b1;
            last_status <= '0;
            last_valid  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state    <= S_START;
                        midi_tx  <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        byte_idx <= skip_status ? 2'd1 : 2'd0;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_DATA;
                        midi_tx  <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state   <= S_STOP;
                            midi_tx <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            midi_tx <= cur_byte[bit_cnt + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_idx == 2'd2) begin
                            state       <= S_IDLE;
                            last_status <= msg_status;
                            last_valid  <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_START;
                            midi_tx  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    midi_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_note_transmitter.sv
// Directed bench for midi_note_transmitter. Uses a scaled bit rate
// (16 clocks per bit) so every message fits in a few hundred cycles.
// dut0: CHANNEL 0 with running status; dut1: CHANNEL 5 without.

module tb_midi_note_transmitter;
    import midi_pkg::*;

    localparam int C = 16;              // clocks per bit for both instances
    localparam int MSG3 = 30 * C + 1;   // acceptance -> ready, 3-byte message
    localparam int MSG2 = 20 * C + 1;   // acceptance -> ready, 2-byte message

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_l;
    note_change_t note0, note1;
    logic         valid0, valid1;
    logic         ready0, tx0, busy0;
    logic         ready1, tx1, busy1;

    int checks = 0;
    int errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    midi_note_transmitter #(.CLOCK_HZ(160), .BAUD(10), .CHANNEL(0), .RUNNING_STATUS(1)) dut0 (
        .clock_50_000_000(clk), .reset_l(reset_l), .note(note0), .note_valid(valid0),
        .note_ready(ready0), .midi_tx(tx0), .busy(busy0)
    );

    midi_note_transmitter #(.CLOCK_HZ(160), .BAUD(10), .CHANNEL(5), .RUNNING_STATUS(0)) dut1 (
        .clock_50_000_000(clk), .reset_l(reset_l), .note(note1), .note_valid(valid1),
        .note_ready(ready1), .midi_tx(tx1), .busy(busy1)
    );

    function automatic note_change_t mk(input logic on, input int nn, input int vel);
        note_change_t n;
        n.status      = on;
        n.note_number = 7'(nn);
        n.velocity    = 7'(vel);
        return n;
    endfunction

    // UART receiver model: samples each bit mid-period, queues received bytes.
    task automatic monitor(input int idx);
        logic [7:0] b;
        logic line;
        forever begin
            @(negedge clk);
            line = (idx == 0) ? tx0 : tx1;
            if (line === 1'b0) begin
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = (idx == 0) ? tx0 : tx1;
                end
                repeat (C) @(negedge clk);
                line = (idx == 0) ? tx0 : tx1;
                if (idx == 0) q0.push_back(b); else q1.push_back(b);
                if (line !== 1'b1) begin
                    if (idx == 0) q0.push_back(8'hEE); else q1.push_back(8'hEE);
                end
            end
        end
    endtask

    task automatic offer0(input note_change_t n);
        note0 = n; valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
    endtask

    task automatic offer1(input note_change_t n);
        note1 = n; valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0;
    endtask

    // Counts cycles from the first cycle after acceptance until ready returns.
    task automatic count_to_ready(input int idx, output int n);
        n = 1;
        while ((((idx == 0) ? ready0 : ready1) !== 1'b1) && n < 100 * C) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_l = 1'b0;
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_l = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
        note0 = mk(1'b1, 0, 0); note1 = mk(1'b1, 0, 0);
        repeat (3) @(negedge clk);
        checks++; if (tx0 !== 1'b1)   begin errors++; $display("FAIL reset_tx0 got %b expected 1", tx0); end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b expected 1", ready0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b expected 0", busy0); end
        checks++; if (tx1 !== 1'b1)   begin errors++; $display("FAIL reset_tx1 got %b expected 1", tx1); end
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({tx0, ready0, busy0} !== 3'b110) begin
            errors++; $display("FAIL post_reset_idle got %b expected 110", {tx0, ready0, busy0});
        end
    endtask

    task automatic test_basic();
        int n;
        logic [23:0] got;
        q0.delete();
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL basic_pre_idle got %b expected 1", tx0); end
        offer0(mk(1'b1, 60, 100));
        checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL basic_start_latency got %b expected 0", tx0); end
        checks++; if ({ready0, busy0} !== 2'b01) begin
            errors++; $display("FAIL basic_busy got %b expected 01", {ready0, busy0});
        end
        count_to_ready(0, n);
        checks++; if (n != MSG3) begin errors++; $display("FAIL basic_length got %0d expected %0d", n, MSG3); end
        repeat (2) @(negedge clk);
        got = (q0.size() == 3) ? {q0[0], q0[1], q0[2]} : 24'hxxxxxx;
        checks++; if (q0.size() != 3) begin errors++; $display("FAIL basic_count got %0d expected 3", q0.size()); end
        checks++; if (got !== 24'h903C64) begin errors++; $display("FAIL basic_bytes got %h expected 903c64", got); end
    endtask

    task automatic test_channel_no_running();
        int n;
        logic [47:0] got;
        q1.delete();
        offer1(mk(1'b0, 60, 64));
        count_to_ready(1, n);
        checks++; if (n != MSG3) begin errors++; $display("FAIL ch5_len1 got %0d expected %0d", n, MSG3); end
        @(negedge clk);
        offer1(mk(1'b0, 60, 64));
        count_to_ready(1, n);
        checks++; if (n != MSG3) begin errors++; $display("FAIL ch5_len2 got %0d expected %0d", n, MSG3); end
        repeat (2) @(negedge clk);
        got = (q1.size() == 6) ? {q1[0], q1[1], q1[2], q1[3], q1[4], q1[5]} : 48'hx;
        checks++; if (got !== 48'h853C40_853C40) begin
            errors++; $display("FAIL ch5_bytes got %h count %0d expected 853c40853c40", got, q1.size());
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [63:0] got;
        do_reset();
        q0.delete();
        note0 = mk(1'b1, 60, 100); valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        note0 = mk(1'b1, 64, 90);
        count_to_ready(0, n);
        checks++; if (n != MSG3) begin errors++; $display("FAIL b2b_len1 got %0d expected %0d", n, MSG3); end
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL b2b_gap_line got %b expected 1", tx0); end
        @(negedge clk);
        checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL b2b_start2 got %b expected 0", tx0); end
        note0 = mk(1'b0, 60, 0);
        count_to_ready(0, n);
        checks++; if (n != MSG2) begin errors++; $display("FAIL b2b_len2 got %0d expected %0d", n, MSG2); end
        @(negedge clk);
        valid0 = 1'b0;
        checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL b2b_start3 got %b expected 0", tx0); end
        count_to_ready(0, n);
        checks++; if (n != MSG3) begin errors++; $display("FAIL b2b_len3 got %0d expected %0d", n, MSG3); end
        repeat (2) @(negedge clk);
        got = (q0.size() == 8) ? {q0[0], q0[1], q0[2], q0[3], q0[4], q0[5], q0[6], q0[7]} : 64'hx;
        checks++; if (got !== 64'h903C6440_5A803C00) begin
            errors++; $display("FAIL b2b_bytes got %h count %0d expected 903c64405a803c00", got, q0.size());
        end
    endtask

    task automatic test_hold_while_busy();
        int n;
        logic [39:0] got;
        q0.delete();
        note0 = mk(1'b1, 60, 100); valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            repeat (5 * C) @(negedge clk);
            note0 = mk(k[0], 10 + k, 20 + k);
        end
        note0 = mk(1'b1, 70, 50);
        count_to_ready(0, n);
        @(negedge clk);
        valid0 = 1'b0;
        count_to_ready(0, n);
        checks++; if (n != MSG2) begin errors++; $display("FAIL hold_len2 got %0d expected %0d", n, MSG2); end
        repeat (6 * C) @(negedge clk);
        got = (q0.size() == 5) ? {q0[0], q0[1], q0[2], q0[3], q0[4]} : 40'hx;
        checks++; if (got !== 40'h903C644632) begin
            errors++; $display("FAIL hold_bytes got %h count %0d expected 903c644632", got, q0.size());
        end
    endtask

    task automatic test_reset_mid_message();
        int n;
        logic [23:0] got;
        q0.delete();
        offer0(mk(1'b0, 61, 10));       // 0x80 0x3D 0x0A
        repeat (10 * C + 2 * C + C / 2) @(negedge clk);
        checks++; if (tx0 !== 1'b0) begin errors++; $display("FAIL midreset_prebit got %b expected 0", tx0); end
        #2;
        reset_l = 1'b0;
        valid0  = 1'b1;
        note0   = mk(1'b1, 60, 100);
        #1;
        checks++; if ({tx0, ready0, busy0} !== 3'b110) begin
            errors++; $display("FAIL midreset_async got %b expected 110", {tx0, ready0, busy0});
        end
        repeat (3) @(negedge clk);
        checks++; if ({tx0, ready0} !== 2'b11) begin
            errors++; $display("FAIL midreset_valid_ignored got %b expected 11", {tx0, ready0});
        end
        valid0  = 1'b0;
        reset_l = 1'b1;
        repeat (12 * C) @(negedge clk);
        q0.delete();
        offer0(mk(1'b1, 60, 100));
        count_to_ready(0, n);
        checks++; if (n != MSG3) begin errors++; $display("FAIL midreset_len got %0d expected %0d", n, MSG3); end
        repeat (2) @(negedge clk);
        got = (q0.size() == 3) ? {q0[0], q0[1], q0[2]} : 24'hxxxxxx;
        checks++; if (got !== 24'h903C64) begin
            errors++; $display("FAIL midreset_bytes got %h count %0d expected 903c64", got, q0.size());
        end
    endtask

    task automatic test_idle_line();
        int bad;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ({tx0, busy0, tx1, busy1} !== 4'b1010) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_line got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
        test_reset();
        test_basic();
        test_channel_no_running();
        test_back_to_back();
        test_hold_while_busy();
        test_reset_mid_message();
        test_idle_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
